// File: rtl/snake_head_ctrl.sv
// Snake head controller: game-speed tick prescaler, direction
// filtering (reversals rejected) and head stepping on a torus grid.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   direction  decoder code: 011 up, 010 left, 001 down, 000 right,
//              100 stop/reset, 101..111 ignored
//   head_x     head column, 0..GRID_W-1
//   head_y     head row, 0..GRID_H-1 (0 = top)
//   move_stb   one-cycle pulse in the cycle head_x/head_y show a new cell
//   running    1 while the game is running
//   cur_dir    direction applied on the last move
module snake_head_ctrl #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int X_W      = 5,
    parameter int Y_W      = 5,
    parameter int TICK_DIV = 2500000,
    parameter int START_X  = 16,
    parameter int START_Y  = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2:0]     direction,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic           move_stb,
    output logic           running,
    output logic [1:0]     cur_dir
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [X_W-1:0]   X_START   = X_W'(START_X);
    localparam logic [Y_W-1:0]   Y_START   = Y_W'(START_Y);
    localparam logic [X_W-1:0]   X_LAST    = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(GRID_H - 1);

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     dir_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]     pend_q, pend_d;
    logic [1:0]     cur_dir_q, cur_dir_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           stb_q, stb_d;

    logic           dir_valid;
    logic           dir_stop;
    logic           tick;
    logic [1:0]     step_dir;
    logic [X_W-1:0] step_x;
    logic [Y_W-1:0] step_y;

    assign dir_valid = ~dir_q[2];
    assign dir_stop  = (dir_q == 3'b100);
    assign tick      = (cnt_q == TICK_LAST);

    // Opposite codes differ only in bit 1 (00/10 and 01/11), so a
    // reversal request keeps the current heading.
    assign step_dir = ((pend_q ^ cur_dir_q) == 2'b10) ? cur_dir_q : pend_q;

    // Wrap by explicit bound compare so non power-of-two grids work.
    always_comb begin
        step_x = x_q;
        step_y = y_q;
        unique case (step_dir)
            DIR_RIGHT: step_x = (x_q == X_LAST) ? '0 : x_q + X_W'(1);
            DIR_LEFT:  step_x = (x_q == '0) ? X_LAST : x_q - X_W'(1);
            DIR_DOWN:  step_y = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
            DIR_UP:    step_y = (y_q == '0) ? Y_LAST : y_q - Y_W'(1);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = dir_valid ? dir_q[1:0] : pend_q;
        cur_dir_d = cur_dir_q;
        x_d       = x_q;
        y_d       = y_q;
        stb_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (dir_valid) begin
                    cur_dir_d = dir_q[1:0];
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (dir_stop) begin
                    // Stop has priority over a coinciding tick.
                    state_d = IDLE;
                    cnt_d   = '0;
                    x_d     = X_START;
                    y_d     = Y_START;
                end else if (tick) begin
                    cnt_d     = '0;
                    cur_dir_d = step_dir;
                    x_d       = step_x;
                    y_d       = step_y;
                    stb_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dir_q     <= 3'b100;
            cnt_q     <= '0;
            pend_q    <= 2'b00;
            cur_dir_q <= 2'b00;
            x_q       <= X_START;
            y_q       <= Y_START;
            stb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= direction;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            cur_dir_q <= cur_dir_d;
            x_q       <= x_d;
            y_q       <= y_d;
            stb_q     <= stb_d;
        end
    end

    assign head_x   = x_q;
    assign head_y   = y_q;
    assign move_stb = stb_q;
    assign running  = (state_q == RUN);
    assign cur_dir  = cur_dir_q;

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Testbench for snake_head_ctrl: directed vector table, wrap and
// reset corner sequences, and random stimulus against a reference model.
module tb_snake_head_ctrl;

    localparam int GW   = 32;
    localparam int GH   = 24;
    localparam int X_W  = 5;
    localparam int Y_W  = 5;
    localparam int TICK = 4;
    localparam int SX   = 16;
    localparam int SY   = 12;

    logic           clk;
    logic           rst;
    logic [2:0]     direction;
    logic [X_W-1:0] head_x;
    logic [Y_W-1:0] head_y;
    logic           move_stb;
    logic           running;
    logic [1:0]     cur_dir;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_x, m_y, m_dir, m_pend, m_age, m_in;
    bit m_run, m_stb;

    typedef struct {
        logic       r;
        logic [2:0] d;
        int         ex;
        int         ey;
        logic       es;
        logic       er;
        logic [1:0] ec;
    } vec_t;

    vec_t vecs[$];

    snake_head_ctrl #(
        .GRID_W  (GW),
        .GRID_H  (GH),
        .X_W     (X_W),
        .Y_W     (Y_W),
        .TICK_DIV(TICK),
        .START_X (SX),
        .START_Y (SY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .direction(direction),
        .head_x   (head_x),
        .head_y   (head_y),
        .move_stb (move_stb),
        .running  (running),
        .cur_dir  (cur_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_opposite(int a, int b);
        // 0 right, 1 down, 2 left, 3 up
        return (a == 0 && b == 2) || (a == 2 && b == 0) ||
               (a == 1 && b == 3) || (a == 3 && b == 1);
    endfunction

    task automatic model_edge(input logic r, input logic [2:0] d);
        int code;
        code  = m_in;
        m_stb = 1'b0;
        if (r) begin
            m_x = SX; m_y = SY; m_run = 1'b0; m_dir = 0;
            m_pend = 0; m_age = 0; m_in = 4;
        end else begin
            if (!m_run) begin
                if (code < 4) begin
                    m_dir = code;
                    m_run = 1'b1;
                    m_age = 0;
                end
            end else if (code == 4) begin
                m_run = 1'b0;
                m_x = SX;
                m_y = SY;
                m_age = 0;
            end else if (m_age == TICK - 1) begin
                m_age = 0;
                if (!is_opposite(m_pend, m_dir)) m_dir = m_pend;
                case (m_dir)
                    0: m_x = (m_x + 1) % GW;
                    2: m_x = (m_x + GW - 1) % GW;
                    1: m_y = (m_y + 1) % GH;
                    default: m_y = (m_y + GH - 1) % GH;
                endcase
                m_stb = 1'b1;
            end else begin
                m_age = m_age + 1;
            end
            if (code < 4) m_pend = code;
            m_in = int'(d);
        end
    endtask

    task automatic cmp_out(input string nm, input int ex, input int ey,
                           input logic es, input logic er,
                           input logic [1:0] ec);
        n_checks++;
        if (head_x !== X_W'(ex) || head_y !== Y_W'(ey) ||
            move_stb !== es || running !== er || cur_dir !== ec) begin
            n_fail++;
            $display("FAIL %s t=%0t got x=%0d y=%0d stb=%b run=%b dir=%b want x=%0d y=%0d stb=%b run=%b dir=%b",
                     nm, $time, head_x, head_y, move_stb, running, cur_dir,
                     ex, ey, es, er, ec);
        end
    endtask

    task automatic cmp_int(input string nm, input logic [31:0] got,
                           input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s t=%0t got %0d want %0d", nm, $time, got, want);
        end
    endtask

    task automatic step(input logic r, input logic [2:0] d);
        rst       = r;
        direction = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
        cmp_out("model", m_x, m_y, m_stb, m_run, 2'(m_dir));
    endtask

    task automatic add(input logic r, input logic [2:0] d, input int ex,
                       input int ey, input logic es, input logic er,
                       input logic [1:0] ec);
        vec_t v;
        v.r = r; v.d = d; v.ex = ex; v.ey = ey;
        v.es = es; v.er = er; v.ec = ec;
        vecs.push_back(v);
    endtask

    initial begin
        int strobes;
        int budget;
        logic [2:0] cur;

        rst = 1'b1;
        direction = 3'b100;
        m_x = SX; m_y = SY; m_run = 0; m_stb = 0;
        m_dir = 0; m_pend = 0; m_age = 0; m_in = 4;

        // reset, start right, three moves
        add(1, 3'd4, 16, 12, 0, 0, 2'd0);
        add(1, 3'd4, 16, 12, 0, 0, 2'd0);
        add(0, 3'd0, 16, 12, 0, 0, 2'd0);
        add(0, 3'd0, 16, 12, 0, 1, 2'd0);
        add(0, 3'd0, 16, 12, 0, 1, 2'd0);
        add(0, 3'd0, 16, 12, 0, 1, 2'd0);
        add(0, 3'd0, 16, 12, 0, 1, 2'd0);
        add(0, 3'd0, 17, 12, 1, 1, 2'd0);
        add(0, 3'd0, 17, 12, 0, 1, 2'd0);
        add(0, 3'd0, 17, 12, 0, 1, 2'd0);
        add(0, 3'd0, 17, 12, 0, 1, 2'd0);
        add(0, 3'd0, 18, 12, 1, 1, 2'd0);
        add(0, 3'd0, 18, 12, 0, 1, 2'd0);
        add(0, 3'd0, 18, 12, 0, 1, 2'd0);
        add(0, 3'd0, 18, 12, 0, 1, 2'd0);
        add(0, 3'd0, 19, 12, 1, 1, 2'd0);
        // reversal to left rejected
        add(0, 3'd2, 19, 12, 0, 1, 2'd0);
        add(0, 3'd2, 19, 12, 0, 1, 2'd0);
        add(0, 3'd2, 19, 12, 0, 1, 2'd0);
        add(0, 3'd2, 20, 12, 1, 1, 2'd0);
        // turn up
        add(0, 3'd3, 20, 12, 0, 1, 2'd0);
        add(0, 3'd3, 20, 12, 0, 1, 2'd0);
        add(0, 3'd3, 20, 12, 0, 1, 2'd0);
        add(0, 3'd3, 20, 11, 1, 1, 2'd3);
        add(0, 3'd3, 20, 11, 0, 1, 2'd3);
        add(0, 3'd3, 20, 11, 0, 1, 2'd3);
        // stop lands on the tick edge
        add(0, 3'd4, 20, 11, 0, 1, 2'd3);
        add(0, 3'd4, 16, 12, 0, 0, 2'd3);
        // ignored code
        add(0, 3'd6, 16, 12, 0, 0, 2'd3);
        add(0, 3'd6, 16, 12, 0, 0, 2'd3);
        add(0, 3'd6, 16, 12, 0, 0, 2'd3);

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].d);
            cmp_out($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey,
                    vecs[i].es, vecs[i].er, vecs[i].ec);
        end

        // right across x=31 -> 0
        strobes = 0;
        budget  = 0;
        while (strobes < 16 && budget < 100) begin
            step(0, 3'd0);
            budget++;
            if (move_stb === 1'b1) begin
                strobes++;
                cmp_int("wrap_right_x", 32'(head_x), (SX + strobes) % GW);
            end
        end
        cmp_int("wrap_right_strobes", strobes, 16);
        cmp_int("wrap_right_final_x", 32'(head_x), 0);

        // up across y=0 -> 23
        strobes = 0;
        budget  = 0;
        while (strobes < 13 && budget < 80) begin
            step(0, 3'd3);
            budget++;
            if (move_stb === 1'b1) begin
                strobes++;
                cmp_int("wrap_up_y", 32'(head_y), (SY - strobes + GH) % GH);
            end
        end
        cmp_int("wrap_up_strobes", strobes, 13);
        cmp_int("wrap_up_final_y", 32'(head_y), 23);

        // reset exactly on a tick edge
        budget = 0;
        while (m_age != TICK - 1 && budget < 10) begin
            step(0, 3'd3);
            budget++;
        end
        cmp_int("rst_tick_align", m_age, TICK - 1);
        step(1, 3'd4);
        cmp_out("rst_on_tick", 16, 12, 0, 0, 2'd0);
        step(0, 3'd4);
        cmp_out("rst_after", 16, 12, 0, 0, 2'd0);

        // random stimulus vs model
        cur = 3'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                step(1, 3'(4 + $urandom_range(0, 3)));
            end else begin
                if ($urandom_range(0, 9) < 3) cur = 3'($urandom_range(0, 7));
                step(0, cur);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
